// File: rtl/fpu_cmd_issuer_if.sv
// Bus bundle between the command issuer and its environment: command port,
// the three FPU operand streams, the FPU result stream and the response port.
interface fpu_cmd_issuer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [7:0]       cmd_op;

    logic             s_axis_a_tvalid;
    logic             s_axis_a_tready;
    logic [31:0]      s_axis_a_tdata;
    logic             s_axis_b_tvalid;
    logic             s_axis_b_tready;
    logic [31:0]      s_axis_b_tdata;
    logic             s_axis_operation_tvalid;
    logic             s_axis_operation_tready;
    logic [7:0]       s_axis_operation_tdata;

    logic             m_axis_result_tvalid;
    logic             m_axis_result_tready;
    logic [31:0]      m_axis_result_tdata;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [1:0]       rsp_err;

    logic [CNT_W-1:0] ok_count;
    logic [CNT_W-1:0] err_count;

    // Issuer side
    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op,
        output cmd_ready,
        output s_axis_a_tvalid, s_axis_a_tdata,
        input  s_axis_a_tready,
        output s_axis_b_tvalid, s_axis_b_tdata,
        input  s_axis_b_tready,
        output s_axis_operation_tvalid, s_axis_operation_tdata,
        input  s_axis_operation_tready,
        input  m_axis_result_tvalid, m_axis_result_tdata,
        output m_axis_result_tready,
        output rsp_valid, rsp_data, rsp_err,
        input  rsp_ready,
        output ok_count, err_count
    );

    // Environment side (sequencer plus FPU core)
    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op,
        input  cmd_ready,
        input  s_axis_a_tvalid, s_axis_a_tdata,
        output s_axis_a_tready,
        input  s_axis_b_tvalid, s_axis_b_tdata,
        output s_axis_b_tready,
        input  s_axis_operation_tvalid, s_axis_operation_tdata,
        output s_axis_operation_tready,
        output m_axis_result_tvalid, m_axis_result_tdata,
        input  m_axis_result_tready,
        input  rsp_valid, rsp_data, rsp_err,
        output rsp_ready,
        input  ok_count, err_count
    );
endinterface

// File: rtl/fpu_cmd_issuer.sv
// Issues one FPU command over the A/B/operation streams, waits (bounded) for
// the result and returns it with a status code; keeps ok/error statistics.
module fpu_cmd_issuer #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    fpu_cmd_issuer_if.master bus
);

    localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;
    localparam logic [7:0]  OP_MAX = 8'd3;
    localparam logic [1:0]  ERR_OK = 2'd0;
    localparam logic [1:0]  ERR_OP = 2'd1;
    localparam logic [1:0]  ERR_TO = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             a_vld_q, a_vld_d;
    logic             b_vld_q, b_vld_d;
    logic             op_vld_q, op_vld_d;
    logic [31:0]      a_data_q, a_data_d;
    logic [31:0]      b_data_q, b_data_d;
    logic [7:0]       op_data_q, op_data_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            a_vld_q     <= 1'b0;
            b_vld_q     <= 1'b0;
            op_vld_q    <= 1'b0;
            a_data_q    <= '0;
            b_data_q    <= '0;
            op_data_q   <= '0;
            to_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_OK;
            ok_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            a_vld_q     <= a_vld_d;
            b_vld_q     <= b_vld_d;
            op_vld_q    <= op_vld_d;
            a_data_q    <= a_data_d;
            b_data_q    <= b_data_d;
            op_data_q   <= op_data_d;
            to_cnt_q    <= to_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        // Each operand channel drops its valid independently once handshaken.
        a_vld_d   = a_vld_q  & ~bus.s_axis_a_tready;
        b_vld_d   = b_vld_q  & ~bus.s_axis_b_tready;
        op_vld_d  = op_vld_q & ~bus.s_axis_operation_tready;
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;
        op_data_d = op_data_q;
        to_cnt_d  = to_cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        ok_cnt_d   = ok_cnt_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    a_data_d  = bus.cmd_a;
                    b_data_d  = bus.cmd_b;
                    op_data_d = bus.cmd_op;
                    if (bus.cmd_op > OP_MAX) begin
                        state_d    = ST_RESP;
                        rsp_err_d  = ERR_OP;
                        rsp_data_d = QNAN;
                    end else begin
                        state_d  = ST_ISSUE;
                        a_vld_d  = 1'b1;
                        b_vld_d  = 1'b1;
                        op_vld_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (!a_vld_d && !b_vld_d && !op_vld_d) begin
                    state_d  = ST_WAIT;
                    to_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                // A result in the final counted cycle still beats the timeout.
                if (bus.m_axis_result_tvalid) begin
                    state_d    = ST_RESP;
                    rsp_data_d = bus.m_axis_result_tdata;
                    rsp_err_d  = ERR_OK;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d    = ST_RESP;
                    rsp_data_d = QNAN;
                    rsp_err_d  = ERR_TO;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    if (rsp_err_q == ERR_OK) begin
                        if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + CNT_W'(1);
                    end else begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    assign bus.cmd_ready               = cmd_ready_q;
    assign bus.s_axis_a_tvalid         = a_vld_q;
    assign bus.s_axis_a_tdata          = a_data_q;
    assign bus.s_axis_b_tvalid         = b_vld_q;
    assign bus.s_axis_b_tdata          = b_data_q;
    assign bus.s_axis_operation_tvalid = op_vld_q;
    assign bus.s_axis_operation_tdata  = op_data_q;
    // Results are always sunk; beats outside WAIT are stale and dropped.
    assign bus.m_axis_result_tready    = 1'b1;
    assign bus.rsp_valid               = rsp_valid_q;
    assign bus.rsp_data                = rsp_data_q;
    assign bus.rsp_err                 = rsp_err_q;
    assign bus.ok_count                = ok_cnt_q;
    assign bus.err_count               = err_cnt_q;

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Bench for fpu_cmd_issuer: FPU stub with programmable tready delays and
// latency, a vector table, randomized ops against a reference model, resets.
module tb_fpu_cmd_issuer;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 16;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  op;
        int          lat;      // stub latency after last operand; 0 = never answers
        int          dly_a;
        int          dly_b;
        int          dly_o;
        int          hold;     // cycles rsp_ready stays low
        int          inj;      // cycle to inject a stale result beat, 0 = none
        logic [31:0] res;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_cmd_issuer_if #(.CNT_W(CNT_W)) bus();

    fpu_cmd_issuer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [CNT_W-1:0] ok_m  = '0;
    logic [CNT_W-1:0] err_m = '0;

    // Stub configuration (written by the sequencer) and observations (by the stub)
    int          st_lat = 0;
    int          st_dly [3];
    logic [31:0] st_res = '0;
    int          op_id  = 0;
    int          inj_cnt = 0;
    int          hs_cnt = 0;
    logic [31:0] cap [3];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s #%0d: got %h, want %h", nm, idx, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                                input int lat, input int da, input int db, input int dop,
                                input int hold, input int inj, input logic [31:0] res,
                                input logic [31:0] ed, input logic [1:0] ee);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.lat = lat;
        v.dly_a = da; v.dly_b = db; v.dly_o = dop;
        v.hold = hold; v.inj = inj; v.res = res;
        v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    // Reference: illegal op -> err 1, no answer within TIMEOUT WAIT cycles -> err 2.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.op > 8'd3) begin
            r.exp_data = QNAN; r.exp_err = 2'd1;
        end else if (v.lat == 0 || v.lat > int'(TIMEOUT)) begin
            r.exp_data = QNAN; r.exp_err = 2'd2;
        end else begin
            r.exp_data = v.res; r.exp_err = 2'd0;
        end
        return r;
    endfunction

    function automatic int max3(input int x, input int y, input int z);
        int m = x;
        if (y > m) m = y;
        if (z > m) m = z;
        return m;
    endfunction

    // FPU stub: works on falling edges, drives tready/result ahead of the next rising edge.
    initial begin : stub
        int seen_id, inj_seen, cd, ncyc [3], fall [3];
        logic got [3], rdy [3], tv [3], armed, pend;
        logic [31:0] td [3], prev [3];
        seen_id = 0; inj_seen = 0; cd = 0; armed = 1'b0; pend = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ncyc[c] = 0; fall[c] = 0; got[c] = 1'b0; rdy[c] = 1'b0; prev[c] = '0;
        end
        bus.s_axis_a_tready = 1'b0;
        bus.s_axis_b_tready = 1'b0;
        bus.s_axis_operation_tready = 1'b0;
        bus.m_axis_result_tvalid = 1'b0;
        bus.m_axis_result_tdata  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int c = 0; c < 3; c++) begin
                    ncyc[c] = 0; fall[c] = 0; got[c] = 1'b0; rdy[c] = 1'b0;
                end
                armed = 1'b0; pend = 1'b0;
                bus.s_axis_a_tready = 1'b0;
                bus.s_axis_b_tready = 1'b0;
                bus.s_axis_operation_tready = 1'b0;
                bus.m_axis_result_tvalid = 1'b0;
            end else begin
                if (op_id != seen_id) begin
                    seen_id = op_id; armed = 1'b0; hs_cnt = 0;
                    for (int c = 0; c < 3; c++) got[c] = 1'b0;
                end
                bus.m_axis_result_tvalid = 1'b0;
                tv[0] = bus.s_axis_a_tvalid;         td[0] = bus.s_axis_a_tdata;
                tv[1] = bus.s_axis_b_tvalid;         td[1] = bus.s_axis_b_tdata;
                tv[2] = bus.s_axis_operation_tvalid; td[2] = {24'h0, bus.s_axis_operation_tdata};
                for (int c = 0; c < 3; c++) begin
                    if (fall[c] != 0) begin
                        chk("tvalid_fall_after_hs", c, 32'(tv[c]), 32'd0);
                        fall[c] = 0;
                    end
                    if (tv[c]) begin
                        ncyc[c]++;
                        if (ncyc[c] > 1) chk("tdata_stable", c, td[c], prev[c]);
                        prev[c] = td[c];
                        rdy[c] = (ncyc[c] > st_dly[c]);
                        if (rdy[c]) begin
                            got[c] = 1'b1; cap[c] = td[c]; hs_cnt++; ncyc[c] = 0; fall[c] = 1;
                        end
                    end else begin
                        rdy[c] = 1'b0; ncyc[c] = 0;
                    end
                end
                bus.s_axis_a_tready = rdy[0];
                bus.s_axis_b_tready = rdy[1];
                bus.s_axis_operation_tready = rdy[2];
                if (pend) begin
                    cd--;
                    if (cd == 0) begin
                        pend = 1'b0;
                        bus.m_axis_result_tvalid = 1'b1;
                        bus.m_axis_result_tdata  = st_res;
                    end
                end
                if (got[0] && got[1] && got[2] && !armed) begin
                    armed = 1'b1;
                    if (st_lat > 0) begin pend = 1'b1; cd = st_lat; end
                end
                if (inj_cnt != inj_seen) begin
                    inj_seen = inj_cnt;
                    bus.m_axis_result_tvalid = 1'b1;
                    bus.m_axis_result_tdata  = 32'hDEAD_BEEF;
                end
            end
        end
    end

    task automatic chk_reset(input int idx);
        chk("rst_cmd_ready", idx, 32'(bus.cmd_ready), 32'd1);
        chk("rst_a_tvalid",  idx, 32'(bus.s_axis_a_tvalid), 32'd0);
        chk("rst_b_tvalid",  idx, 32'(bus.s_axis_b_tvalid), 32'd0);
        chk("rst_op_tvalid", idx, 32'(bus.s_axis_operation_tvalid), 32'd0);
        chk("rst_a_tdata",   idx, bus.s_axis_a_tdata, 32'd0);
        chk("rst_b_tdata",   idx, bus.s_axis_b_tdata, 32'd0);
        chk("rst_op_tdata",  idx, 32'(bus.s_axis_operation_tdata), 32'd0);
        chk("rst_rsp_valid", idx, 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data",  idx, bus.rsp_data, 32'd0);
        chk("rst_rsp_err",   idx, 32'(bus.rsp_err), 32'd0);
        chk("rst_ok_count",  idx, 32'(bus.ok_count), 32'd0);
        chk("rst_err_count", idx, 32'(bus.err_count), 32'd0);
        chk("rst_result_tready", idx, 32'(bus.m_axis_result_tready), 32'd1);
    endtask

    // Assert reset mid-cycle; outputs must clear before the next clock edge.
    task automatic pulse_rst(input int idx);
        @(posedge clk); #2 rst = 1'b1; #1;
        chk_reset(idx);
        ok_m = '0; err_m = '0;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the falling edge of cycle 1 (cycle 0 = accept cycle).
    task automatic send_cmd(input vec_t v, input int idx);
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_ready_idle", idx, 32'(bus.cmd_ready), 32'd1);
        st_lat = v.lat; st_res = v.res;
        st_dly[0] = v.dly_a; st_dly[1] = v.dly_b; st_dly[2] = v.dly_o;
        op_id++;
        bus.cmd_a = v.a; bus.cmd_b = v.b; bus.cmd_op = v.op;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_a = $urandom; bus.cmd_b = $urandom; bus.cmd_op = 8'($urandom);
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int t, exp_t, maxd;
        maxd = max3(v.dly_a, v.dly_b, v.dly_o);
        if (v.op > 8'd3)                              exp_t = 1;
        else if (v.lat == 0 || v.lat > int'(TIMEOUT)) exp_t = 2 + maxd + int'(TIMEOUT);
        else                                          exp_t = 2 + maxd + v.lat;
        send_cmd(v, idx);
        t = 1;
        while (!bus.rsp_valid && t < 200) begin
            chk("cmd_ready_busy", idx, 32'(bus.cmd_ready), 32'd0);
            if (v.inj == t) inj_cnt++;
            @(negedge clk);
            t++;
        end
        chk("rsp_latency", idx, 32'(t), 32'(exp_t));
        for (int i = 0; i <= v.hold; i++) begin
            chk("rsp_valid", idx, 32'(bus.rsp_valid), 32'd1);
            chk("rsp_data",  idx, bus.rsp_data, v.exp_data);
            chk("rsp_err",   idx, 32'(bus.rsp_err), 32'(v.exp_err));
            chk("cmd_ready_in_resp", idx, 32'(bus.cmd_ready), 32'd0);
            if (i == v.hold) bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        if (v.exp_err == 2'd0) begin
            if (ok_m != '1) ok_m = ok_m + 1'b1;
        end else begin
            if (err_m != '1) err_m = err_m + 1'b1;
        end
        chk("cmd_ready_after_rsp", idx, 32'(bus.cmd_ready), 32'd1);
        chk("rsp_valid_after_rsp", idx, 32'(bus.rsp_valid), 32'd0);
        chk("ok_count",  idx, 32'(bus.ok_count), 32'(ok_m));
        chk("err_count", idx, 32'(bus.err_count), 32'(err_m));
        if (v.op > 8'd3) begin
            chk("no_issue_on_illegal", idx, 32'(hs_cnt), 32'd0);
        end else begin
            chk("operand_handshakes", idx, 32'(hs_cnt), 32'd3);
            chk("issued_a",  idx, cap[0], v.a);
            chk("issued_b",  idx, cap[1], v.b);
            chk("issued_op", idx, cap[2], {24'h0, v.op});
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl [10];
        vec_t v;
        int n;
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
        bus.rsp_ready = 1'b0;
        st_dly[0] = 0; st_dly[1] = 0; st_dly[2] = 0;

        tbl[0] = mk(32'h40C8F5C3, 32'h40C8F5C3, 8'd3, 8, 0, 0, 0, 0,  0, 32'h3F800000, 32'h3F800000, 2'd0);
        tbl[1] = mk(32'h40C8F5C3, 32'h40C8F5C3, 8'd0, 8, 0, 5, 0, 1,  0, 32'h4148F5C3, 32'h4148F5C3, 2'd0);
        tbl[2] = mk(32'h40C8F5C3, 32'h40C8F5C3, 8'h07, 8, 0, 0, 0, 0, 0, 32'h12345678, QNAN, 2'd1);
        tbl[3] = mk(32'h3F800000, 32'h40000000, 8'h04, 5, 0, 0, 0, 2, 0, 32'h11111111, QNAN, 2'd1);
        tbl[4] = mk(32'h3F800000, 32'h40000000, 8'd2, 16, 1, 0, 2, 0, 0, 32'h40000000, 32'h40000000, 2'd0);
        tbl[5] = mk(32'h40400000, 32'h3F800000, 8'd1, 17, 0, 0, 0, 0, 0, 32'h40000000, QNAN, 2'd2);
        tbl[6] = mk(32'h40400000, 32'h3F800000, 8'd2, 0, 0, 0, 0, 10, 0, 32'h40400000, QNAN, 2'd2);
        tbl[7] = mk(32'h40400000, 32'h3F800000, 8'd0, 8, 0, 3, 0, 0, 2, 32'h40800000, 32'h40800000, 2'd0);
        tbl[8] = mk(32'hC0000000, 32'h3F800000, 8'd1, 1, 3, 0, 1, 0, 0, 32'hC0400000, 32'hC0400000, 2'd0);
        tbl[9] = mk(32'h00000000, 32'h00000000, 8'hFF, 1, 0, 0, 0, 0, 0, 32'h0, QNAN, 2'd1);

        repeat (3) @(negedge clk);
        chk_reset(0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_op(tbl[i], i);

        // Reset while B is still stalled in ISSUE, then a stale beat while idle.
        v = mk(32'h40C8F5C3, 32'h3F800000, 8'd2, 8, 0, 5, 0, 0, 0, 32'h40C8F5C3, 32'h40C8F5C3, 2'd0);
        send_cmd(v, 100);
        @(negedge clk);
        pulse_rst(100);
        inj_cnt++;
        repeat (3) @(negedge clk);
        chk("stale_idle_rsp_valid", 100, 32'(bus.rsp_valid), 32'd0);
        chk("stale_idle_ok_count",  100, 32'(bus.ok_count), 32'd0);
        chk("stale_idle_cmd_ready", 100, 32'(bus.cmd_ready), 32'd1);
        run_op(v, 101);

        // Reset while a response is waiting for rsp_ready.
        v = mk(32'h3F800000, 32'h3F800000, 8'd0, 3, 0, 0, 0, 0, 0, 32'h40000000, 32'h40000000, 2'd0);
        send_cmd(v, 102);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk("rsp_valid_before_rst", 102, 32'(bus.rsp_valid), 32'd1);
        pulse_rst(102);
        run_op(v, 103);

        for (int i = 0; i < 40; i++) begin
            v.a     = $urandom;
            v.b     = $urandom;
            v.op    = 8'($urandom_range(0, 5));
            v.lat   = $urandom_range(0, 16);
            v.dly_a = $urandom_range(0, 4);
            v.dly_b = $urandom_range(0, 4);
            v.dly_o = $urandom_range(0, 4);
            v.hold  = $urandom_range(0, 3);
            v.inj   = 0;
            v.res   = $urandom;
            v.exp_data = '0;
            v.exp_err  = '0;
            run_op(model(v), 200 + i);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fpu_cmd_issuer.md
# fpu_cmd_issuer

Command-side driver for the `FPU` core. It accepts one floating-point command at a time (A, B, operator) over a valid/ready port and issues it on the core's three AXI-stream input channels. It then collects the single-precision result from the core's `m_axis_result` channel and returns it on a response port with a status code. It sits between the control logic or test sequencer and `FPU`, and replaces hand-driven operand registers.

## Interface

Parameters:
- `TIMEOUT`, 64: maximum cycles spent in WAIT before aborting; must exceed the FPU worst-case latency.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_a` in 32, `cmd_b` in 32: IEEE-754 single operands.
- `cmd_op` in 8: 0 add, 1 sub, 2 mul, 3 div; any other value is illegal.
- `s_axis_a_tvalid` out 1, `s_axis_a_tready` in 1, `s_axis_a_tdata` out 32: operand A channel.
- `s_axis_b_tvalid` out 1, `s_axis_b_tready` in 1, `s_axis_b_tdata` out 32: operand B channel.
- `s_axis_operation_tvalid` out 1, `s_axis_operation_tready` in 1, `s_axis_operation_tdata` out 8: operator channel.
- `m_axis_result_tvalid` in 1, `m_axis_result_tready` out 1, `m_axis_result_tdata` in 32: result channel.
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_data` out 32: response.
- `rsp_err` out 2: 0 ok, 1 illegal op, 2 timeout.
- `ok_count` out CNT_W, `err_count` out CNT_W: saturating counts of responses accepted with err=0 and err≠0.

## Operation

- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch a, b and op.
  - If op>3, go to RESP with `rsp_err`=1 and `rsp_data`=32'h7FC00000. Nothing is issued to the FPU.
  - Otherwise go to ISSUE and set all three s_axis tvalids to 1.
- **ISSUE:** each channel is independent.
  - A channel's tvalid falls the cycle after its tvalid&&tready handshake.
  - tdata stays stable while tvalid=1.
  - When all three channels have completed, go to WAIT. Channels may complete in any order or in the same cycle.
- **WAIT:** the timeout counter increments every cycle.
  - On `m_axis_result_tvalid`, latch tdata into `rsp_data`, set `rsp_err`=0 and go to RESP.
  - If the counter reaches TIMEOUT-1 with no result, go to RESP with `rsp_err`=2 and `rsp_data`=32'h7FC00000.
  - If a result arrives in that same final cycle, the result wins.
- **RESP:** `rsp_valid`=1. `rsp_data` and `rsp_err` are held until `rsp_valid && rsp_ready`, then go to IDLE and update the matching counter (saturates at all-ones).
- `m_axis_result_tready` is constant 1. Any result beat arriving outside WAIT is a stale result from an aborted op and is discarded, with no counter change.
- `cmd_ready` is 0 in every state except IDLE. `cmd_*` inputs are ignored outside IDLE.

## Timing

- **Reset values:** state=IDLE, `cmd_ready`=1, all s_axis tvalids=0, all tdata=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, both counters=0, timeout counter=0.
- **Reset mid-operation:** reset asserted in any state clears immediately (asynchronous). Partially issued operands are abandoned, and the result from that op is discarded as stale.
- **Latency:**
  - Command accept edge at cycle 0: tvalids=1 in cycle 1.
  - With tready tied high: WAIT is entered in cycle 2.
  - A result beat in cycle k: `rsp_valid`=1 in cycle k+1.
  - Illegal op: `rsp_valid`=1 in cycle 1.
- **Back-to-back:** the response handshake at cycle n gives `cmd_ready`=1 in cycle n+1. Throughput is one op per (FPU latency + 4) cycles minimum.
- **Timeout counter:** cleared on entry to WAIT; it does not wrap.

## Test plan

- Div, `cmd_a`=`cmd_b`=32'h40C8F5C3 (6.28), `cmd_op`=3, against an FPU stub with 8-cycle latency and tready=1 → each tvalid high exactly 1 cycle; `rsp_data`=32'h3F800000, `rsp_err`=0, `ok_count`=1.
- Add with the same operands, with the B channel tready delayed 5 cycles → `s_axis_a`/`s_axis_operation` tvalid drop after 1 cycle and `s_axis_b_tvalid` is held 6 cycles with stable data; `rsp_data`=32'h4148F5C3.
- `cmd_op`=8'h07 → no s_axis tvalid ever asserts; `rsp_valid` in cycle 1 with `rsp_err`=1 and `rsp_data`=32'h7FC00000; `err_count`=1.
- Stub never returns, TIMEOUT=16 → `rsp_err`=2 after 16 WAIT cycles. A late result injected during the next command's ISSUE is discarded, and the next op returns its own correct value.
- `rsp_ready` held low 10 cycles → `rsp_data`/`rsp_err` stable and `cmd_ready`=0 throughout.
- `rst` pulsed mid-ISSUE and mid-RESP → all outputs at reset values within the same cycle; counters=0.
